// File: rtl/key_onehot_debouncer.sv
// Conditions eight bouncy key lines for the 8-to-3 encoder: 2-flop sync, per-bit debounce,
// then a small FSM that only lets a single clean, held key through and blocks multi-presses.
module key_onehot_debouncer #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] raw_in,
  output logic [7:0] key_out,
  output logic       press,
  // "release" is a reserved word in SystemVerilog, hence the suffix
  output logic       release_o,
  output logic       multi
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressed, StBlocked} state_e;

  logic [7:0]       s1_q, s2_q;
  logic [7:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  state_e           state_q, state_d;
  logic [7:0]       key_out_q, key_out_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             multi_q, multi_d;
  logic             is_zero, is_one;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // x & (x-1) clears the lowest set bit; zero result means at most one bit was set
  assign is_zero = (stable_q == 8'h00);
  assign is_one  = !is_zero && ((stable_q & (stable_q - 8'd1)) == 8'h00);

  always_comb begin
    state_d   = state_q;
    key_out_d = key_out_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_one) begin
          state_d   = StPressed;
          key_out_d = stable_q;
          press_d   = 1'b1;
        end else if (!is_zero) begin
          state_d = StBlocked;
        end
      end
      StPressed: begin
        if (stable_q == key_out_q) begin
          state_d = StPressed;
        end else if (is_zero) begin
          state_d   = StIdle;
          key_out_d = 8'h00;
          release_d = 1'b1;
        end else begin
          // Added or swapped key: drop the output silently, no release pulse
          state_d   = StBlocked;
          key_out_d = 8'h00;
        end
      end
      StBlocked: begin
        if (is_zero) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        key_out_d = 8'h00;
      end
    endcase
    multi_d = (state_d == StBlocked);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 8'h00;
      s2_q      <= 8'h00;
      stable_q  <= 8'h00;
      cnt_q     <= '{default: '0};
      state_q   <= StIdle;
      key_out_q <= 8'h00;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      s1_q      <= raw_in;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      key_out_q <= key_out_d;
      press_q   <= press_d;
      release_q <= release_d;
      multi_q   <= multi_d;
    end
  end

  assign key_out   = key_out_q;
  assign press     = press_q;
  assign release_o = release_q;
  assign multi     = multi_q;

endmodule

// File: tb/tb_key_onehot_debouncer.sv
// Bench for key_onehot_debouncer: directed scenarios plus random key activity, all checked
// every cycle against a window-based reference model of sync, debounce and one-hot gating.
module tb_key_onehot_debouncer;

  localparam int Deb = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] raw_in = 8'h00;
  logic [7:0] key_out;
  logic       press, release_o, multi;

  int n_cmp = 0;
  int n_err = 0;
  int n_press = 0;
  int n_rel = 0;

  // Reference model state
  logic [7:0] m_hist [$];
  logic [7:0] m_stable, m_key;
  int         m_state;  // 0 idle, 1 pressed, 2 blocked
  logic       m_press, m_rel, m_multi;

  key_onehot_debouncer #(.DEB_CYCLES(Deb)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (raw_in),
    .key_out  (key_out),
    .press    (press),
    .release_o(release_o),
    .multi    (multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k <= Deb; k++) m_hist.push_back(8'h00);
    m_stable = 8'h00;
    m_key    = 8'h00;
    m_state  = 0;
    m_press  = 1'b0;
    m_rel    = 1'b0;
    m_multi  = 1'b0;
  endtask

  // One rising edge with raw value r present. Outputs react to the stable value held before
  // the edge; a stable bit flips once the synchronised line disagreed for Deb samples in a row.
  task automatic model_edge(input logic [7:0] r);
    int ones;
    ones    = $countones(m_stable);
    m_press = 1'b0;
    m_rel   = 1'b0;
    case (m_state)
      0: if (ones == 1) begin
           m_state = 1; m_key = m_stable; m_press = 1'b1;
         end else if (ones > 1) m_state = 2;
      1: if (m_stable != m_key) begin
           m_key = 8'h00;
           if (ones == 0) begin m_state = 0; m_rel = 1'b1; end
           else m_state = 2;
         end
      default: if (ones == 0) m_state = 0;
    endcase
    m_multi = (m_state == 2);
    // m_hist[k] holds raw from k+1 edges ago; synchronised samples are m_hist[1..Deb]
    for (int b = 0; b < 8; b++) begin
      bit flip = 1'b1;
      for (int k = 1; k <= Deb; k++) if (m_hist[k][b] == m_stable[b]) flip = 1'b0;
      if (flip) m_stable[b] = ~m_stable[b];
    end
    m_hist.push_front(r);
    void'(m_hist.pop_back());
  endtask

  task automatic step(input logic [7:0] r);
    raw_in = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check("key_out", {24'h0, key_out}, {24'h0, m_key});
    check("press", {31'h0, press}, {31'h0, m_press});
    check("release", {31'h0, release_o}, {31'h0, m_rel});
    check("multi", {31'h0, multi}, {31'h0, m_multi});
    check("onehot0", {31'h0, $onehot0(key_out)}, 32'd1);
    check("press_while_multi", {31'h0, press & multi}, 32'd0);
    if (press) n_press++;
    if (release_o) n_rel++;
  endtask

  // Hold r until the chosen event is seen; n = edges taken, 99 on timeout.
  // which: 0 press, 1 release, 2 multi rises, 3 multi falls
  task automatic hold_until(input logic [7:0] r, input int which, output int n);
    bit hit;
    n = 99;
    for (int i = 1; i <= 30; i++) begin
      step(r);
      case (which)
        0: hit = press;
        1: hit = release_o;
        2: hit = multi;
        default: hit = !multi;
      endcase
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic settle(input logic [7:0] r, input int cycles);
    for (int i = 0; i < cycles; i++) step(r);
  endtask

  initial begin
    int n;
    logic [7:0] cur;
    model_reset();
    #1;
    check("reset_key_out", {24'h0, key_out}, 32'h0);
    check("reset_pulses", {30'h0, press, release_o}, 32'h0);
    check("reset_multi", {31'h0, multi}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    settle(8'h00, 5);

    // Clean single press and release
    hold_until(8'h08, 0, n);
    check("clean_press_latency", n, 7);
    check("clean_key", {24'h0, key_out}, 32'h08);
    settle(8'h08, 3);
    hold_until(8'h00, 1, n);
    check("clean_release_latency", n, 7);
    settle(8'h00, 4);

    // Bounce shorter than the debounce window
    n_press = 0;
    for (int c = 0; c < 20; c++) step(((c / 2) % 2) == 0 ? 8'h01 : 8'h00);
    check("bounce_no_press", n_press, 0);
    check("bounce_key", {24'h0, key_out}, 32'h0);
    hold_until(8'h01, 0, n);
    check("bounce_hold_latency", n, 7);
    hold_until(8'h00, 1, n);
    settle(8'h00, 4);

    // Two keys together
    n_press = 0;
    hold_until(8'h21, 2, n);
    check("multi_latency", n, 7);
    check("multi_key", {24'h0, key_out}, 32'h0);
    settle(8'h20, 10);
    check("lone_key_blocked", {31'h0, multi}, 32'd1);
    check("multi_no_press", n_press, 0);
    hold_until(8'h00, 3, n);
    check("unblock_latency", n, 7);
    settle(8'h00, 4);

    // Key added while pressed
    hold_until(8'h04, 0, n);
    check("add_press_latency", n, 7);
    n_rel = 0;
    hold_until(8'h44, 2, n);
    check("add_multi_latency", n, 7);
    check("add_key_dropped", {24'h0, key_out}, 32'h0);
    check("add_no_release", n_rel, 0);
    settle(8'h00, 12);
    check("add_back_idle", {31'h0, multi}, 32'd0);

    // Reset mid-press with key held
    hold_until(8'h80, 0, n);
    check("pre_reset_key", {24'h0, key_out}, 32'h80);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {key_out, press, release_o, multi}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold_until(8'h80, 0, n);
    check("post_reset_press_latency", n, 7);
    check("post_reset_key", {24'h0, key_out}, 32'h80);
    hold_until(8'h00, 1, n);
    settle(8'h00, 4);

    // Random key activity with occasional single-cycle glitches
    cur = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0:       cur = 8'h00;
          1, 2:    cur = 8'h01 << $urandom_range(7);
          default: cur = 8'($urandom);
        endcase
      end
      if ($urandom_range(15) == 0) step(cur ^ (8'h01 << $urandom_range(7)));
      else step(cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_onehot_debouncer.md
# key_onehot_debouncer

Upstream conditioning stage for the 8-to-3 key encoder. Synchronises and debounces eight raw, bouncy key lines, then enforces the one-hot contract before presenting the vector. The encoder only ever sees all-zero or a single clean, held key. Ambiguous multi-key presses are flagged and blocked until every key is released.

## Interface
- `DEB_CYCLES`, default 4, number of consecutive cycles a synchronised bit must disagree with its stable value before the stable value flips (legal range ≥ 1).
- `CNT_W`, default `$clog2(DEB_CYCLES+1)`, width of the per-bit debounce counter; derived, not overridden.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `raw_in`  in  8  asynchronous key lines, active high.
- `key_out`  out  8  registered one-hot (or zero) vector feeding the encoder `in` port.
- `press`  out  1  one-cycle pulse, asserted in the cycle `key_out` first becomes non-zero.
- `release`  out  1  one-cycle pulse, asserted in the cycle `key_out` returns to zero after a clean press.
- `multi`  out  1  level, high while in BLOCKED.

## Operation
- **Synchroniser:** two flops per bit, `s1 <= raw_in` and `s2 <= s1`. Reset value is 0.
- **Debounce (per bit i):**
  - `stable[i]` and counter `cnt[i]` both reset to 0.
  - If `s2[i] == stable[i]`, then `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == DEB_CYCLES-1`, then `stable[i] <= s2[i]` and `cnt[i] <= 0`.
  - Otherwise, `cnt[i] <= cnt[i]+1`.
  - A disagreement shorter than `DEB_CYCLES` cycles never reaches `stable`.
- **Classification of `stable`:** ZERO means no bits set. ONE means exactly one bit set. MANY means two or more bits set.
- **FSM, 3 states, reset to IDLE:**
  - **IDLE:**
    - ZERO: stay.
    - ONE: go to PRESSED; `key_out <= stable`; `press <= 1`.
    - MANY: go to BLOCKED.
  - **PRESSED:**
    - `stable == key_out`: stay.
    - ZERO: go to IDLE; `key_out <= 0`; `release <= 1`.
    - Any other value (second key added, or key swapped): go to BLOCKED; `key_out <= 0`; no `release` pulse.
  - **BLOCKED:**
    - ZERO: go to IDLE.
    - Otherwise stay. A lone key remaining after a multi-press never produces `press`.
- **Registered outputs:**
  - `press` and `release` default to 0 every cycle.
  - `multi` is registered equal to (next_state == BLOCKED).
  - `key_out` is always 0 or one-hot; this is an invariant.
- **Reset:** all flops, counters, `stable`, the FSM, and all outputs go to 0 / IDLE immediately on `rst_n` low, including mid-press. After reset is released, a key still held is re-detected through the full sync+debounce path and produces a fresh `press`.

## Timing
- Reset values:
  - `key_out` = 8'h00, `press` = 0, `release` = 0, `multi` = 0.
  - FSM in IDLE.
- Latency from a stable `raw_in` change to `stable`: `DEB_CYCLES+2` rising edges. `s2` updates on edge 2; `stable` flips on edge `DEB_CYCLES+2`.
- Outputs (`key_out`, `press`, `release`, `multi`) update one edge after `stable`: `DEB_CYCLES+3` edges total. With the default this is 7 edges.
- The `press` / `release` pulse is exactly 1 cycle wide and aligned with the `key_out` transition edge.
- There is no back-pressure; the downstream encoder is combinational.
- Simultaneous events:
  - Bits flipping in the same cycle are debounced independently.
  - The FSM acts on the `stable` vector as a whole each cycle. Two keys whose stable edges coincide are classified MANY; there is no ordering or priority.
- Counter wrap is impossible: it is cleared at `DEB_CYCLES-1`.

## Test plan
- **Clean single press** (`DEB_CYCLES`=4): `raw_in` = 8'h08 held → `key_out` = 8'h08 and a one-cycle `press` at edge 7. Release to 8'h00 → `key_out` = 0 and a one-cycle `release` 7 edges later. `multi` stays 0 throughout.
- **Bounce rejection:** `raw_in` toggles 8'h01/8'h00 every 2 cycles for 20 cycles → `key_out` stays 0 and no `press`. Then hold 8'h01 → `press` 7 edges after the hold begins.
- **Two keys together:** `raw_in` = 8'h21 → `multi` = 1 at edge 7, `key_out` = 0, no `press`. Drop to 8'h20 → still BLOCKED, no `press`. Drop to 8'h00 → `multi` = 0 seven edges later.
- **Key added while pressed:** `raw_in` = 8'h04, wait for `press`, then 8'h44 → `key_out` goes 8'h04→8'h00 and `multi` = 1 on the same edge, no `release`. Then 8'h00 → IDLE.
- **Reset mid-press:** in PRESSED with `key_out` = 8'h80, pulse `rst_n` low for 1 cycle while `raw_in` stays 8'h80 → all outputs 0 asynchronously. A fresh `press` with `key_out` = 8'h80 follows 7 edges after `rst_n` rises.
- **One-hot invariant:** random `raw_in` for 10k cycles → `key_out` is always 0 or one-hot every cycle. `press` is never asserted while `multi` is 1.
